// File: rtl/atm_pkg.sv
// atm_pkg: shared definitions for the ATM ledger arbiter slice.
//   - opcode encodings for the 2-bit per-terminal op field
//   - FSM state encoding (also exported on the top's dbg_state port)
//   - default widths used as parameter defaults by atm_ledger_arbiter
package atm_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BAL  = 2'b01;
  localparam logic [1:0] OP_DEP  = 2'b10;
  localparam logic [1:0] OP_WD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } atm_state_e;

  localparam int DEF_NUM_ACCT = 4;
  localparam int DEF_AMT_W    = 20;
  localparam int DEF_BAL_W    = 32;

endpackage

// File: rtl/atm_rr_arb2.sv
// atm_rr_arb2: two-way round-robin picker.
//   req      [1:0]  request per terminal
//   last_gnt        terminal granted most recently
//   win             chosen terminal (meaningful only when valid)
//   valid           at least one request present
// A lone requester always wins; on a tie the terminal that was not granted
// last time wins.
module atm_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       win,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) win = ~last_gnt;
    else              win = req[1];
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter: shared account ledger serving two ATM terminals.
// One balance read-modify-write per transaction, round-robin between
// terminals, three cycles per transaction (IDLE -> EXEC -> RESP).
//
// Handshake: a terminal raises req[i] with op/acct/amount stable and holds
// it until done[i] pulses; gnt[i] marks the EXEC cycle, done[i]/ok/resp_bal
// are valid together for the single RESP cycle. The terminal drops req in
// the cycle after done; a req still high in IDLE is a new request.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   req[1:0]      per-terminal request
//   op[3:0]       op[2i+1:2i] for terminal i (none/balance/deposit/withdraw)
//   acct          ACCT_W-bit account index per terminal
//   amount        AMT_W-bit amount per terminal (zero-extended)
//   gnt, done     one-hot grant (EXEC) and completion pulse (RESP)
//   ok, resp_bal  status and post-transaction balance, valid with done
//   busy          high in EXEC and RESP
//   dbg_state     current FSM state
//
// Optional feature: define ATM_LEDGER_WD_LIMIT_EN to add a per-account
// cumulative withdraw counter that caps total withdrawals at WD_LIMIT.
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int                NUM_ACCT = DEF_NUM_ACCT,
  parameter int                AMT_W    = DEF_AMT_W,
  parameter int                BAL_W    = DEF_BAL_W,
  parameter logic [BAL_W-1:0]  INIT_BAL = BAL_W'(1000),
  parameter logic [BAL_W-1:0]  WD_LIMIT = BAL_W'(5000),
  localparam int               ACCT_W   = (NUM_ACCT > 1) ? $clog2(NUM_ACCT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [3:0]           op,
  input  logic [2*ACCT_W-1:0]  acct,
  input  logic [2*AMT_W-1:0]   amount,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic                 ok,
  output logic [BAL_W-1:0]     resp_bal,
  output logic                 busy,
  output atm_state_e           dbg_state
);

  localparam logic [ACCT_W:0] ACCT_LIM = (ACCT_W+1)'(NUM_ACCT);

  atm_state_e         state;
  logic               win_q;
  logic               last_gnt;
  logic [1:0]         op_q;
  logic [ACCT_W-1:0]  acct_q;
  logic [BAL_W-1:0]   amt_q;
  logic [BAL_W-1:0]   bal [NUM_ACCT];

  logic               arb_win;
  logic               arb_valid;
  logic               acct_in_range;
  logic [BAL_W-1:0]   cur_bal;
  logic [BAL_W:0]     dep_sum;
  logic               wd_ok;
  logic               nx_ok;
  logic [BAL_W-1:0]   nx_bal;

  atm_rr_arb2 u_arb (
    .req      (req),
    .last_gnt (last_gnt),
    .win      (arb_win),
    .valid    (arb_valid)
  );

  assign dbg_state     = state;
  assign acct_in_range = ({1'b0, acct_q} < ACCT_LIM);

  // Out-of-range accounts read as zero so resp_bal reports 0 for them.
  always_comb begin
    cur_bal = '0;
    if (acct_in_range) cur_bal = bal[acct_q];
  end

  // Extra carry bit catches deposit overflow.
  assign dep_sum = {1'b0, cur_bal} + {1'b0, amt_q};

`ifdef ATM_LEDGER_WD_LIMIT_EN
  logic [BAL_W-1:0] wd_cnt [NUM_ACCT];
  logic [BAL_W:0]   wd_sum;

  always_comb begin
    wd_sum = {1'b0, amt_q};
    if (acct_in_range) wd_sum = {1'b0, wd_cnt[acct_q]} + {1'b0, amt_q};
  end

  assign wd_ok = (wd_sum <= {1'b0, WD_LIMIT});

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCT; i++) wd_cnt[i] <= '0;
    end else if (state == ST_EXEC && nx_ok && op_q == OP_WD) begin
      wd_cnt[acct_q] <= wd_sum[BAL_W-1:0];
    end
  end
`else
  logic [BAL_W-1:0] wd_limit_unused;
  assign wd_limit_unused = WD_LIMIT;
  assign wd_ok           = 1'b1;
`endif

  // Transaction result; a failing op leaves the balance untouched.
  always_comb begin
    nx_ok  = 1'b0;
    nx_bal = cur_bal;
    if (acct_in_range) begin
      case (op_q)
        OP_BAL: nx_ok = 1'b1;
        OP_DEP: begin
          if (!dep_sum[BAL_W]) begin
            nx_ok  = 1'b1;
            nx_bal = dep_sum[BAL_W-1:0];
          end
        end
        OP_WD: begin
          if ((amt_q <= cur_bal) && wd_ok) begin
            nx_ok  = 1'b1;
            nx_bal = cur_bal - amt_q;
          end
        end
        default: nx_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      win_q    <= 1'b0;
      last_gnt <= 1'b1;
      op_q     <= OP_NONE;
      acct_q   <= '0;
      amt_q    <= '0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      ok       <= 1'b0;
      resp_bal <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < NUM_ACCT; i++) bal[i] <= INIT_BAL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            win_q    <= arb_win;
            last_gnt <= arb_win;
            op_q     <= arb_win ? op[3:2] : op[1:0];
            acct_q   <= arb_win ? acct[2*ACCT_W-1:ACCT_W] : acct[ACCT_W-1:0];
            amt_q    <= BAL_W'(arb_win ? amount[2*AMT_W-1:AMT_W] : amount[AMT_W-1:0]);
            gnt      <= arb_win ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          gnt      <= 2'b00;
          done     <= win_q ? 2'b10 : 2'b01;
          ok       <= nx_ok;
          resp_bal <= nx_bal;
          // nx_ok implies the account index is in range.
          if (nx_ok) bal[acct_q] <= nx_bal;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          done     <= 2'b00;
          ok       <= 1'b0;
          resp_bal <= '0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/atm_ledger_arbiter.md
# atm_ledger_arbiter

Shared account-ledger controller arbitrating two ATM front-ends (terminal 0, terminal 1) onto a single balance read-modify-write datapath. Holds NUM_ACCT account balances, serialises balance/deposit/withdraw transactions with round-robin fairness, and returns a pass/fail status and updated balance to the winning terminal. Sits between the ATM session FSMs and the account storage.

## Interface
- NUM_ACCT, 4: number of accounts; index width ACCT_W = $clog2(NUM_ACCT).
- AMT_W, 20: transaction amount width.
- BAL_W, 32: balance width.
- INIT_BAL, 32'd1000: value loaded into every balance on reset.
- WD_LIMIT, 32'd5000: cumulative withdraw limit per account; used only when the limit feature is compiled in.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  2  per-terminal request; held high until that terminal's done.
- op  in  4  op[2i+1:2i] for terminal i: 00 none, 01 balance, 10 deposit, 11 withdraw.
- acct  in  2*ACCT_W  account index per terminal.
- amount  in  2*AMT_W  amount per terminal, zero-extended to BAL_W.
- gnt  out  2  one-hot; high for the EXEC cycle of the granted terminal.
- done  out  2  one-hot; one-cycle pulse in RESP.
- ok  out  1  valid with done; 1 = transaction succeeded.
- resp_bal  out  BAL_W  account balance after the transaction, valid with done.
- busy  out  1  high in EXEC and RESP.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any req high, pick winner, latch index/op/acct/amount, go EXEC; else stay.
- Round-robin: last_gnt register; one requester → grant it; both → grant !last_gnt; last_gnt updated on each grant.
- EXEC: gnt[win]=1; compute result; on the edge leaving EXEC, write balance if ok, go RESP.
- RESP: done[win]=1, ok, resp_bal driven; next state IDLE unconditionally.
- Op rules (B = current balance, A = zero-extended amount):
  - 01 balance: ok=1, B unchanged.
  - 10 deposit: if B+A overflows BAL_W, ok=0, unchanged; else B←B+A, ok=1. A=0 → ok=1, unchanged.
  - 11 withdraw: if A>B, ok=0, unchanged; else B←B−A, ok=1. A==B → ok=1, B=0.
  - 00 none, or acct ≥ NUM_ACCT: ok=0, unchanged.
- resp_bal always reports the post-transaction balance of the addressed account (0 when acct is out of range).
- Inputs are sampled only in IDLE; changes during EXEC/RESP are ignored.

## Timing
- Reset values: state=IDLE, gnt=0, done=0, ok=0, resp_bal=0, busy=0, last_gnt=1 (terminal 0 wins the first contest), all balances=INIT_BAL, withdraw counters=0.
- Latency: req sampled high at edge t → gnt high in cycle t+1 → done/ok/resp_bal in cycle t+2 → IDLE in cycle t+3. Throughput: one transaction per 3 cycles.
- Balance write takes effect at the edge ending EXEC; a transaction granted next sees the updated value.
- Requester drops req in the cycle after done; if req is still high in IDLE, it is treated as a new request.
- Simultaneous requests to the same account are serialised; the second sees the first's result.
- Reset in EXEC or RESP: transaction aborted, no done pulse, balances reload INIT_BAL.

## Configuration
- ATM_LEDGER_WD_LIMIT_EN defined: per-account BAL_W cumulative withdrawn counter; withdraw additionally fails (ok=0) if counter+A > WD_LIMIT; counter += A on a successful withdraw; counters cleared only by reset.
- Undefined: no counters, no limit check; WD_LIMIT unused.

## Structure
- Shared package atm_pkg: opcode localparams (OP_NONE, OP_BAL, OP_DEP, OP_WD), state enum encoding, default widths.
- One sub-module: atm_rr_arb2 (2-way round-robin picker: req, last_gnt → winner, valid).
- Balance array and FSM stay in atm_ledger_arbiter.

## Test plan
- Reset, terminal 0 deposit 0x488 to acct 1 → gnt[0] at t+1, done[0] at t+2, ok=1, resp_bal=1000+1160=2160.
- Terminal 1 withdraw 1500 from acct 2 (bal 1000) → ok=0, resp_bal=1000; withdraw 1000 → ok=1, resp_bal=0.
- Both req from reset: terminal 0 granted first, terminal 1 next (done[1] 3 cycles after done[0]); repeat with both held → strict alternation.
- Both deposit 100 to acct 0 simultaneously → resp_bal 1100 then 1200.
- op=00 or acct out of range (NUM_ACCT=3, acct=3) → ok=0, no balance change; deposit 1 to balance 0xFFFFFFFF → ok=0.
- Reset asserted in EXEC of a withdraw → no done, balance reads INIT_BAL; with ATM_LEDGER_WD_LIMIT_EN, WD_LIMIT=1500, acct balance 3000: withdraw 1000 → ok=1, second 1000 → ok=0.
